agen_lsu_queue: RTL and testbench
=================================

AGEN_LSU_QUEUE -- requirements
Module: agen_lsu_queue

Interface
REQ-001 Parameter DEPTH, default 4: entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter PKT_W, default 128: width of one flattened memory packet.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1): occupancy counter width.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-low reset; reset is asserted while reset == 0.
REQ-006 Port recoverFlag_i  input  1: branch-recovery flush.
REQ-007 Port exceptionFlag_i  input  1: exception flush.
REQ-008 Port memValid_i  input  1: agen packet valid from the memory execute pipe.
REQ-009 Port memPacket_i  input  PKT_W: agen packet payload.
REQ-010 Port memStall_o  output  1: back-pressure to the memory issue lane.
REQ-011 Port lsuValid_o  output  1: head entry valid toward the LSU.
REQ-012 Port lsuPacket_o  output  PKT_W: head entry payload.
REQ-013 Port lsuReady_i  input  1: LSU accepts the head entry this cycle.
REQ-014 Port count_o  output  CNT_W: current occupancy.
REQ-015 Port overflow_o  output  1: sticky error, a valid packet was dropped while full.

Function
REQ-016 The block SHALL be a circular FIFO with head and tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a count register of 0..DEPTH.
REQ-017 flush = recoverFlag_i | exceptionFlag_i.
REQ-018 Push SHALL occur when memValid_i & ~flush & (count < DEPTH | pop); payload written at tail, tail+1.
REQ-019 lsuValid_o SHALL equal (count != 0) & ~flush, combinationally.
REQ-020 lsuPacket_o SHALL equal the entry at head; value is don't-care when lsuValid_o == 0.
REQ-021 Pop SHALL occur when lsuValid_o & lsuReady_i; head+1.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; this is legal at full, where push is accepted.
REQ-023 Minimum latency: a packet pushed in cycle N SHALL appear at lsuValid_o/lsuPacket_o in cycle N+1 if the queue was empty; no combinational path exists from memPacket_i to lsuPacket_o.
REQ-024 Ordering SHALL be strict FIFO; no entry is reordered or duplicated.
REQ-025 memStall_o SHALL be registered, and SHALL be 1 in the cycle after count reaches DEPTH-1 or more, so that the one in-flight packet always fits.
REQ-026 Drop rule: memValid_i & ~flush & count == DEPTH & ~pop SHALL discard the packet and set overflow_o to 1.
REQ-027 overflow_o SHALL hold until reset; flush SHALL NOT clear it.
REQ-028 On flush, the next state SHALL be: head = tail = 0, count = 0, memStall_o = 0.
REQ-029 In the flush cycle, a same-cycle push SHALL be discarded, with no overflow, and no pop SHALL be counted.
REQ-030 count_o SHALL equal the count register directly.

Reset
REQ-031 While reset == 0 at a clock edge, the next state SHALL be: head = tail = 0, count_o = 0, lsuValid_o = 0, memStall_o = 0, overflow_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; reset has priority over flush, push and pop.
REQ-033 Entry storage SHALL need no reset.

Verification
REQ-034 Push A, B, C on consecutive cycles with lsuReady_i = 0 -> count_o is 1, 2, 3; memStall_o = 1 from the cycle after count = 3; lsuPacket_o = A throughout.
REQ-035 DEPTH = 4 full, then memValid_i = 1 with lsuReady_i = 1 -> push accepted, count_o stays 4, overflow_o = 0, the popped entry is the oldest.
REQ-036 DEPTH = 4 full, then memValid_i = 1 with lsuReady_i = 0 -> packet dropped, count_o = 4, overflow_o = 1 and sticky through a later flush.
REQ-037 Queue holds 3 entries; recoverFlag_i = 1 in the same cycle as memValid_i = 1 and lsuReady_i = 1 -> lsuValid_o = 0 in that cycle, count_o = 0 next cycle, overflow_o unchanged.
REQ-038 Run 20 push/pop pairs through DEPTH = 4 with a random-ready pattern -> output sequence equals input sequence across pointer wrap-around, and count_o never exceeds 4.
REQ-039 reset = 0 for one cycle with 2 entries held and overflow_o = 1 -> next cycle count_o = 0, lsuValid_o = 0, overflow_o = 0, memStall_o = 0.

Source files
------------

// File: rtl/agen_lsu_queue_if.sv
// agen_lsu_queue_if
//   Handshake bundle between the memory execute pipe, the agen/LSU queue and
//   the LSU.
//   master : producer/consumer side (drives memValid_i, memPacket_i, lsuReady_i)
//   slave  : the queue itself (drives memStall_o, lsuValid_o, lsuPacket_o,
//            count_o, overflow_o)
interface agen_lsu_queue_if #(
    parameter int PKT_W = 128,
    parameter int CNT_W = 3
);
    logic             memValid_i;
    logic [PKT_W-1:0] memPacket_i;
    logic             memStall_o;
    logic             lsuValid_o;
    logic [PKT_W-1:0] lsuPacket_o;
    logic             lsuReady_i;
    logic [CNT_W-1:0] count_o;
    logic             overflow_o;

    modport master (
        output memValid_i, memPacket_i, lsuReady_i,
        input  memStall_o, lsuValid_o, lsuPacket_o, count_o, overflow_o
    );

    modport slave (
        input  memValid_i, memPacket_i, lsuReady_i,
        output memStall_o, lsuValid_o, lsuPacket_o, count_o, overflow_o
    );
endinterface

// File: rtl/agen_lsu_queue.sv
// agen_lsu_queue
//   Circular FIFO buffering agen packets from the memory execute pipe toward
//   the LSU. Flushed on branch recovery or exception; drops (and flags) a
//   packet that arrives while full with no same-cycle pop.
//   clk, reset        : clock, synchronous active-low reset
//   recoverFlag_i     : branch-recovery flush
//   exceptionFlag_i   : exception flush
//   bus (slave)       : mem push side, lsu pop side, occupancy, sticky overflow
module agen_lsu_queue #(
    parameter int DEPTH = 4,                  // power of two, 2..16
    parameter int PKT_W = 128,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic recoverFlag_i,
    input  logic exceptionFlag_i,
    agen_lsu_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] headQ, tailQ;
    logic [CNT_W-1:0] countQ;
    logic             stallQ;
    logic             overflowQ;

    logic flush, full, pop, push, drop;

    always_comb begin
        flush = recoverFlag_i | exceptionFlag_i;
        full  = (countQ == CNT_W'(DEPTH));
        pop   = bus.lsuValid_o & bus.lsuReady_i;
        // A pop frees the slot in the same cycle, so a push at full is legal then.
        push  = bus.memValid_i & ~flush & (~full | pop);
        drop  = bus.memValid_i & ~flush & full & ~pop;
    end

    assign bus.lsuValid_o  = (countQ != '0) & ~flush;
    assign bus.lsuPacket_o = mem[headQ];
    assign bus.count_o     = countQ;
    assign bus.memStall_o  = stallQ;
    assign bus.overflow_o  = overflowQ;

    // Payload storage carries no reset; validity is tracked by countQ alone.
    always_ff @(posedge clk) begin
        if (push) mem[tailQ] <= bus.memPacket_i;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            headQ     <= '0;
            tailQ     <= '0;
            countQ    <= '0;
            stallQ    <= 1'b0;
            overflowQ <= 1'b0;
        end else if (flush) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            stallQ <= 1'b0;
            // overflowQ is sticky across flushes
        end else begin
            if (push) tailQ <= tailQ + 1'b1;
            if (pop)  headQ <= headQ + 1'b1;
            case ({push, pop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
            if (drop) overflowQ <= 1'b1;
            // Stall once DEPTH-1 is reached; the issue lane may still have one
            // packet in flight when it sees the stall, and that one still fits.
            stallQ <= (countQ >= CNT_W'(DEPTH - 1));
        end
    end
endmodule

// File: tb/tb_agen_lsu_queue.sv
module tb_agen_lsu_queue;
    localparam int DEPTH = 4;
    localparam int PKT_W = 128;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic recoverFlag = 1'b0;
    logic exceptionFlag = 1'b0;

    agen_lsu_queue_if #(.PKT_W(PKT_W), .CNT_W(CNT_W)) bus ();

    agen_lsu_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .recoverFlag_i   (recoverFlag),
        .exceptionFlag_i (exceptionFlag),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of packets plus the sticky/stall flags.
    logic [PKT_W-1:0] refQ [$];
    logic             refOvf = 1'b0;
    logic             refStall = 1'b0;
    int               popsSeen = 0;
    int               maxCount = 0;

    task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] rndPkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle: drive at negedge, check combinational/registered outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input logic v, input logic [PKT_W-1:0] p, input logic r,
                        input logic rec, input logic exc, input logic rst, input string tag);
        logic flush, expValid, doPop, doPush;
        int sz;
        bus.memValid_i  = v;
        bus.memPacket_i = p;
        bus.lsuReady_i  = r;
        recoverFlag     = rec;
        exceptionFlag   = exc;
        reset           = rst;
        #1;
        sz       = refQ.size();
        flush    = rec | exc;
        expValid = (sz != 0) && !flush;
        chk({tag, ".valid"}, PKT_W'(bus.lsuValid_o), PKT_W'(expValid));
        chk({tag, ".count"}, PKT_W'(bus.count_o), PKT_W'(sz));
        chk({tag, ".stall"}, PKT_W'(bus.memStall_o), PKT_W'(refStall));
        chk({tag, ".ovf"},   PKT_W'(bus.overflow_o), PKT_W'(refOvf));
        if (expValid) chk({tag, ".pkt"}, bus.lsuPacket_o, refQ[0]);
        if (int'(bus.count_o) > maxCount) maxCount = int'(bus.count_o);
        @(posedge clk);
        if (!rst) begin
            refQ.delete();
            refOvf   = 1'b0;
            refStall = 1'b0;
        end else if (flush) begin
            refQ.delete();
            refStall = 1'b0;
        end else begin
            doPop    = expValid && r;
            doPush   = v && (sz < DEPTH || doPop);
            refStall = (sz >= DEPTH - 1);
            if (doPop) begin
                void'(refQ.pop_front());
                popsSeen++;
            end
            if (doPush) refQ.push_back(p);
            else if (v) refOvf = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int pushed;
        int cyc;
        logic v;
        bus.memValid_i  = 1'b0;
        bus.memPacket_i = '0;
        bus.lsuReady_i  = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(0, '0, 0, 0, 0, 1, "rst");

        // Three pushes, LSU not ready; stall follows count reaching 3
        step(1, rndPkt(), 0, 0, 0, 1, "pushA");
        step(1, rndPkt(), 0, 0, 0, 1, "pushB");
        step(1, rndPkt(), 0, 0, 0, 1, "pushC");
        step(0, '0, 0, 0, 0, 1, "hold3");
        step(0, '0, 0, 0, 0, 1, "stall3");
        chk("stall.after3", PKT_W'(bus.memStall_o), PKT_W'(1));

        // Fill, then push with pop at full: accepted, count stays 4
        step(1, rndPkt(), 0, 0, 0, 1, "pushD");
        step(1, rndPkt(), 1, 0, 0, 1, "fullPushPop");
        step(0, '0, 0, 0, 0, 1, "fullHold");

        // Push at full without pop: dropped, overflow set
        step(1, rndPkt(), 0, 0, 0, 1, "drop");
        step(0, '0, 0, 0, 0, 1, "afterDrop");

        // Recovery flush with same-cycle push and ready: nothing moves, ovf sticky
        step(1, rndPkt(), 1, 1, 0, 1, "recover");
        step(0, '0, 0, 0, 0, 1, "postRecover");

        // Three entries, then exception flush with push and ready
        step(1, rndPkt(), 0, 0, 0, 1, "p1");
        step(1, rndPkt(), 0, 0, 0, 1, "p2");
        step(1, rndPkt(), 0, 0, 0, 1, "p3");
        step(1, rndPkt(), 1, 0, 1, 1, "except");
        step(0, '0, 0, 0, 0, 1, "postExcept");

        // Clean slate, then 20 packets through with random ready across wrap
        step(0, '0, 0, 0, 0, 0, "rst2");
        popsSeen = 0;
        maxCount = 0;
        pushed   = 0;
        cyc      = 0;
        while ((pushed < 20 || refQ.size() != 0) && cyc < 400) begin
            v = (pushed < 20) && !refStall && ($urandom_range(0, 3) != 0);
            if (v) pushed++;
            step(v, rndPkt(), logic'($urandom_range(0, 1)), 0, 0, 1, "rand");
            cyc++;
        end
        chk("rand.drained", PKT_W'(popsSeen), PKT_W'(20));
        chk("rand.maxCount", PKT_W'(maxCount <= DEPTH), PKT_W'(1));
        chk("rand.noOvf", PKT_W'(bus.overflow_o), PKT_W'(0));

        // Two entries held with overflow set, then a one-cycle reset
        repeat (4) step(1, rndPkt(), 0, 0, 0, 1, "fill");
        step(1, rndPkt(), 0, 0, 0, 1, "drop2");
        step(0, '0, 1, 0, 0, 1, "pop1");
        step(0, '0, 1, 0, 0, 1, "pop2");
        step(0, '0, 0, 0, 0, 1, "held2");
        step(1, rndPkt(), 1, 1, 0, 0, "midReset");
        step(0, '0, 0, 0, 0, 1, "postReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
